iter_mul_div: RTL and testbench

- Parametrised iterative multiply/divide unit alongside the single-cycle ALU in the CPU datapath.
- Executes mult, multu, div and divu over multiple cycles using a start/busy/done handshake.
- Writes a HI/LO result pair, with the MIPS mapping: product high/low, remainder/quotient.
- The control unit stalls the pipeline while busy is high.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/mdu_sign_fix.sv | 36 +++
 rtl/iter_mul_div.sv | 186 ++++++++++++++++++
 tb/tb_iter_mul_div.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes and FSM states.
package cpu_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    // op[1] selects divide, op[0] selects signed operation.
    function automatic logic op_is_div(input logic [1:0] op_i);
        return op_i[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op_i);
        return op_i[0];
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational sign correction: turns unsigned magnitude results into the final HI/LO pair.
module mdu_sign_fix
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [1:0]       op,
    input  logic             sign_a,
    input  logic             sign_b,
    input  logic             div0,
    input  logic [WIDTH-1:0] a_raw,
    input  logic [WIDTH-1:0] mag_hi,
    input  logic [WIDTH-1:0] mag_lo,
    output logic [WIDTH-1:0] hi_c,
    output logic [WIDTH-1:0] lo_c
);

    logic [2*WIDTH-1:0] prod_neg;

    always_comb begin
        prod_neg = -{mag_hi, mag_lo};
        hi_c     = mag_hi;
        lo_c     = mag_lo;
        if (div0) begin
            hi_c = a_raw;
            lo_c = '1;
        end else if (op == OP_MULT && (sign_a ^ sign_b)) begin
            {hi_c, lo_c} = prod_neg;
        end else if (op == OP_DIV) begin
            // Quotient follows the sign product, remainder follows the dividend.
            if (sign_a ^ sign_b) lo_c = -mag_lo;
            if (sign_a)          hi_c = -mag_hi;
        end
    end

endmodule

// File: rtl/iter_mul_div.sv
// Iterative radix-2 multiply/divide unit (mult, multu, div, divu) with start/busy/done handshake.
// Optional: define ITER_MUL_DIV_EARLY_DIV0_EN to finish a divide-by-zero at the accept edge.
module iter_mul_div
    import cpu_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   a_q, a_d, d_q, d_d, q_q, q_d;
    logic [WIDTH:0]     r_q, r_d;
    logic [1:0]         op_q, op_d;
    logic               sa_q, sa_d, sb_q, sb_d;

    logic               accept_c, early_div0_c, last_step_c;
    logic [WIDTH-1:0]   a_mag_c, b_mag_c;
    logic [WIDTH:0]     mul_sum_c, div_shift_c;
    logic [1:0]         fix_op_c;
    logic               fix_sa_c, fix_sb_c, fix_div0_c;
    logic [WIDTH-1:0]   fix_a_c, fix_hi_c, fix_lo_c;

    assign accept_c    = (state_q == IDLE) && start;
    assign last_step_c = (cnt_q == CNT_W'(WIDTH - 1));
    assign a_mag_c     = (op_is_signed(op) && a[WIDTH-1]) ? -a : a;
    assign b_mag_c     = (op_is_signed(op) && b[WIDTH-1]) ? -b : b;
    assign mul_sum_c   = r_q + (q_q[0] ? {1'b0, d_q} : '0);
    assign div_shift_c = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

`ifdef ITER_MUL_DIV_EARLY_DIV0_EN
    assign early_div0_c = accept_c && op_is_div(op) && (b == '0);
`else
    assign early_div0_c = 1'b0;
`endif

    // The early divide-by-zero path feeds the sign fixer from the live inputs.
    assign fix_op_c   = early_div0_c ? op : op_q;
    assign fix_sa_c   = early_div0_c ? 1'b0 : sa_q;
    assign fix_sb_c   = early_div0_c ? 1'b0 : sb_q;
    assign fix_a_c    = early_div0_c ? a : a_q;
    assign fix_div0_c = early_div0_c || (op_is_div(op_q) && (d_q == '0));

    mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .op     (fix_op_c),
        .sign_a (fix_sa_c),
        .sign_b (fix_sb_c),
        .div0   (fix_div0_c),
        .a_raw  (fix_a_c),
        .mag_hi (r_q[WIDTH-1:0]),
        .mag_lo (q_q),
        .hi_c   (fix_hi_c),
        .lo_c   (fix_lo_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c && !early_div0_c) state_d = CALC;
            CALC:    if (last_step_c) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        dbz_d  = dbz_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        a_d    = a_q;
        d_d    = d_q;
        q_d    = q_q;
        r_d    = r_q;
        op_d   = op_q;
        sa_d   = sa_q;
        sb_d   = sb_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    busy_d = 1'b1;
                    dbz_d  = 1'b0;
                    cnt_d  = '0;
                    op_d   = op;
                    a_d    = a;
                    sa_d   = op_is_signed(op) && a[WIDTH-1];
                    sb_d   = op_is_signed(op) && b[WIDTH-1];
                    r_d    = '0;
                    q_d    = op_is_div(op) ? a_mag_c : b_mag_c;
                    d_d    = op_is_div(op) ? b_mag_c : a_mag_c;
                    if (early_div0_c) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                        hi_d   = fix_hi_c;
                        lo_d   = fix_lo_c;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_is_div(op_q)) begin
                    // Restoring step: keep the subtraction only when it does not go negative.
                    if (div_shift_c >= {1'b0, d_q}) begin
                        r_d = div_shift_c - {1'b0, d_q};
                        q_d = {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_d = div_shift_c;
                        q_d = {q_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    r_d = mul_sum_c >> 1;
                    q_d = {mul_sum_c[0], q_q[WIDTH-1:1]};
                end
            end
            FIX: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                dbz_d  = op_is_div(op_q) && (d_q == '0);
                hi_d   = fix_hi_c;
                lo_d   = fix_lo_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            a_q    <= '0;
            d_q    <= '0;
            q_q    <= '0;
            r_q    <= '0;
            op_q   <= OP_MULTU;
            sa_q   <= 1'b0;
            sb_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            dbz_q  <= dbz_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            a_q    <= a_d;
            d_q    <= d_d;
            q_q    <= q_d;
            r_q    <= r_d;
            op_q   <= op_d;
            sa_q   <= sa_d;
            sb_q   <= sb_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_mul_div.sv
// Self-checking bench for iter_mul_div: vector table, scoreboard queue, and multi-cycle corner sequences.
module tb_iter_mul_div;
    import cpu_pkg::*;

    localparam int unsigned W = 32;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    iter_mul_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } res_t;

    res_t sb[$];
    vec_t vecs[10];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [1:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i);
        res_t   r;
        longint sa, sbv, qv, rv;
        logic [63:0] p;
        r.dbz = 1'b0;
        sa  = longint'($signed(a_i));
        sbv = longint'($signed(b_i));
        r.hi = '0;
        r.lo = '0;
        if (op_i[1] && b_i == '0) begin
            r.hi  = a_i;
            r.lo  = '1;
            r.dbz = 1'b1;
        end else begin
            case (op_i)
                OP_MULTU: begin
                    p = 64'(a_i) * 64'(b_i);
                    r.hi = p[63:32];
                    r.lo = p[31:0];
                end
                OP_MULT: begin
                    p = 64'(sa * sbv);
                    r.hi = p[63:32];
                    r.lo = p[31:0];
                end
                OP_DIVU: begin
                    r.lo = a_i / b_i;
                    r.hi = a_i % b_i;
                end
                default: begin
                    qv = sa / sbv;
                    rv = sa % sbv;
                    r.lo = W'(qv);
                    r.hi = W'(rv);
                end
            endcase
        end
        return r;
    endfunction

    function automatic int exp_lat(input logic [1:0] op_i, input logic [W-1:0] b_i);
`ifdef ITER_MUL_DIV_EARLY_DIV0_EN
        if (op_i[1] && b_i == '0) return 1;
`endif
        return int'(W) + 2;
    endfunction

    // One operation: issue, optionally poke a stray start mid-flight, wait for done and score.
    task automatic run_op(input logic [1:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                          input res_t exp, input string tag, input int poke_at);
        int   lat;
        int   bcnt;
        res_t e;
        @(negedge clk);
        start = 1'b1; op = op_i; a = a_i; b = b_i;
        sb.push_back(exp);
        lat  = 0;
        bcnt = 0;
        do begin
            @(negedge clk);
            lat++;
            start = (lat == poke_at);
            if (lat == poke_at) begin
                op = ~op_i; a = a_i ^ 32'h1234_5678; b = b_i + 32'd5;
            end
            if (busy) bcnt++;
        end while (!done && lat < 200);
        start = 1'b0;
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL %s timeout: got no done expected done within 200 cycles", tag);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            check({tag, " hi"}, hi, e.hi);
            check({tag, " lo"}, lo, e.lo);
            check({tag, " dbz"}, W'(div_by_zero), W'(e.dbz));
            check_int({tag, " latency"}, lat, exp_lat(op_i, b_i));
            check_int({tag, " busy cycles"}, bcnt, exp_lat(op_i, b_i) - 1);
        end
    endtask

    initial begin
        res_t        e;
        int          dcnt;
        int          idx;
        int          lat;
        int          guard;
        logic [1:0]  bop[3];
        logic [W-1:0] ba[3];
        logic [W-1:0] bb[3];

        vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[4] = '{OP_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{OP_MULTU, 32'd2,         32'd3,         32'h0000_0000, 32'h0000_0006, 1'b0};
        vecs[6] = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
        vecs[7] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[8] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[9] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, 1'b0};

        repeat (2) @(negedge clk);
        check("reset busy", W'(busy), '0);
        check("reset done", W'(done), '0);
        check("reset hi", hi, '0);
        check("reset lo", lo, '0);
        check("reset dbz", W'(div_by_zero), '0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            e.hi = vecs[i].hi; e.lo = vecs[i].lo; e.dbz = vecs[i].dbz;
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, e, $sformatf("vec%0d", i), (i == 1) ? 5 : 0);
            if (i == 1) begin
                // The stray start must not have queued a second operation.
                dcnt = 0;
                repeat (40) begin
                    @(negedge clk);
                    if (done) dcnt++;
                end
                check_int("ignored start extra done", dcnt, 0);
                check("ignored start hi held", hi, 32'hFFFF_FFFF);
                check("ignored start lo held", lo, 32'hFFFF_FFEB);
            end
        end

        for (int i = 0; i < 8; i++) begin
            logic [1:0]   rop;
            logic [W-1:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 3) ? '0 : $urandom >> $urandom_range(0, 28);
            run_op(rop, ra, rb, model(rop, ra, rb), $sformatf("rnd%0d", i), 0);
        end

        // Back-to-back: start held high, each next op accepted in the done cycle.
        bop[0] = OP_MULT;  ba[0] = 32'hFFFF_FF00; bb[0] = 32'd1000;
        bop[1] = OP_DIVU;  ba[1] = 32'd12345;     bb[1] = 32'd77;
        bop[2] = OP_DIV;   ba[2] = 32'hFFFF_8000; bb[2] = 32'd3;
        @(negedge clk);
        start = 1'b1; op = bop[0]; a = ba[0]; b = bb[0];
        sb.push_back(model(bop[0], ba[0], bb[0]));
        idx = 0; lat = 0; guard = 0;
        while (idx < 3 && guard < 400) begin
            @(negedge clk);
            guard++;
            lat++;
            if (done) begin
                e = sb.pop_front();
                check($sformatf("b2b%0d hi", idx), hi, e.hi);
                check($sformatf("b2b%0d lo", idx), lo, e.lo);
                check_int($sformatf("b2b%0d latency", idx), lat, int'(W) + 2);
                idx++;
                lat = 0;
                if (idx < 3) begin
                    op = bop[idx]; a = ba[idx]; b = bb[idx];
                    sb.push_back(model(bop[idx], ba[idx], bb[idx]));
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        if (idx < 3) begin
            n_cmp++; n_err++;
            $display("FAIL b2b timeout: got %0d results expected 3", idx);
            sb.delete();
        end

        // Asynchronous reset during CALC discards the operation immediately.
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; a = 32'hDEAD_BEEF; b = 32'h0000_1234;
        sb.push_back(model(OP_MULTU, 32'hDEAD_BEEF, 32'h0000_1234));
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre-reset busy", W'(busy), W'(1'b1));
        #1 rst = 1'b1;
        #1;
        check("async rst busy", W'(busy), '0);
        check("async rst done", W'(done), '0);
        check("async rst hi", hi, '0);
        check("async rst lo", lo, '0);
        check("async rst dbz", W'(div_by_zero), '0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        e.hi = 32'd1; e.lo = 32'd3; e.dbz = 1'b0;
        run_op(OP_DIVU, 32'd10, 32'd3, e, "post-reset divu", 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
